// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: sends one accepted word per WIDTH cycles,
// one bit per clock, with a left/right strobe that drives the receiver directly.
module piso_shift_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    input  logic             load_msb_first,
    output logic             load_ready,
    output logic             serial_out,
    output logic             shift_left_o,
    output logic             shift_right_o,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             msb_q, msb_d;
    logic             serial_q, serial_d;
    logic             left_q, left_d;
    logic             right_q, right_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

    // Ready in idle, or on the last bit so the next word can follow with no gap.
    assign load_ready = !rst && (state_q == IDLE || (state_q == SHIFT && cnt_q == LAST));
    assign accept     = load_valid && load_ready;

    // The presented bit always sits at the outgoing end of the shift register,
    // so registered outputs are derived from the next-state register contents.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        msb_d    = msb_q;
        serial_d = 1'b0;
        left_d   = 1'b0;
        right_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sreg_d  = data_in;
            msb_d   = load_msb_first;
        end else if (state_q == SHIFT) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                sreg_d = msb_q ? (sreg_q << 1) : (sreg_q >> 1);
            end
        end

        if (state_d == SHIFT) begin
            serial_d = msb_d ? sreg_d[WIDTH-1] : sreg_d[0];
            left_d   = msb_d;
            right_d  = !msb_d;
            busy_d   = 1'b1;
            done_d   = (cnt_d == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sreg_q   <= '0;
            msb_q    <= 1'b0;
            serial_q <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sreg_q   <= sreg_d;
            msb_q    <= msb_d;
            serial_q <= serial_d;
            left_q   <= left_d;
            right_q  <= right_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign serial_out    = serial_q;
    assign shift_left_o  = left_q;
    assign shift_right_o = right_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in/serial-out transmitter. It is the sending end of the 4-bit bidirectional serial shift receiver.
- Accepts a parallel word over a valid/ready handshake and emits it one bit per clock on serial_out.
- Each bit is accompanied by a direction strobe (shift_left_o or shift_right_o) that drives the receiver's shift_left/shift_right inputs directly.
- After WIDTH strobes, the receiver's data_out holds the transmitted word.

Parameters:
- WIDTH, 4, word width in bits. Legal values: 2..32.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  parallel word to send; sampled only on handshake.
- load_valid  in  1  producer has a word on data_in.
- load_msb_first  in  1  direction for this word; sampled with data_in. 1 = MSB first (left-shift receiver), 0 = LSB first (right-shift receiver).
- load_ready  out  1  block can accept a word this cycle.
- serial_out  out  1  current serial bit.
- shift_left_o  out  1  strobe: serial_out valid, receiver shifts left.
- shift_right_o  out  1  strobe: serial_out valid, receiver shifts right.
- busy  out  1  a word is being shifted out.
- frame_done  out  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- States: IDLE, SHIFT. A bit counter (ceil(log2 WIDTH) bits) counts 0..WIDTH-1. A holding shift register stores the word; a direction flag stores load_msb_first.
- Reset (rst=1 at a clock edge):
  - State goes to IDLE, counter to 0, shift register to 0.
  - serial_out=0, shift_left_o=0, shift_right_o=0, busy=0, frame_done=0.
  - load_ready is forced 0 while rst=1, so no handshake completes during reset.
  - Reset mid-word aborts the word immediately. No further strobes are issued; the partial word is lost.
- load_ready is combinational: !rst && (state==IDLE || (state==SHIFT && counter==WIDTH-1)).
- Accept: load_valid && load_ready at a rising edge captures data_in and load_msb_first. The state becomes or stays SHIFT and the counter resets to 0.
- Latency: the first bit and its strobe appear in the cycle after acceptance. All outputs except load_ready are registered.
- In SHIFT, each cycle presents exactly one bit:
  - MSB first: bit order data[WIDTH-1] down to data[0]; shift_left_o=1, shift_right_o=0.
  - LSB first: bit order data[0] up to data[WIDTH-1]; shift_right_o=1, shift_left_o=0.
  - The two strobes are never high together.
- The counter increments per bit. frame_done=1 exactly in the cycle counter==WIDTH-1.
- End of word:
  - If a new word is accepted in the last-bit cycle, SHIFT continues with no gap. The next word's first bit follows the current last bit on the next cycle.
  - Otherwise the state returns to IDLE.
- busy=1 whenever state==SHIFT.
- In IDLE: serial_out=0, both strobes 0, frame_done=0.
- Changes on data_in or load_msb_first after acceptance have no effect on the word in flight.
- load_valid while load_ready=0 is ignored. The producer must hold the word until ready.
- No bit is ever skipped or repeated. Exactly WIDTH strobes are issued per accepted word (reset excepted).

Test Plan:
1. Reset, then load 4'b1011 with msb_first=1 in one cycle:
   - Next 4 cycles: serial_out = 1,0,1,1 with shift_left_o=1; frame_done only on the 4th.
   - busy falls and load_ready=1 afterwards.
2. Load 4'b1011 with msb_first=0:
   - serial_out = 1,1,0,1 with shift_right_o=1 for 4 cycles; shift_left_o stays 0 throughout.
3. Back-to-back: hold load_valid with 4'b1100 (MSB first), then 4'b0011 (LSB first) presented on the last-bit cycle:
   - 8 consecutive strobes with no idle cycle: 1,1,0,0 (left), then 1,1,0,0 (right).
   - frame_done on cycles 4 and 8.
4. Loopback into the 4-bit shift receiver (shared clk; receiver reset held the same as rst):
   - Send 4'b0110 MSB first, then 4'b1001 LSB first.
   - Receiver data_out equals 4'b0110 after the 4th strobe, then 4'b1001 after the 8th.
5. Assert rst after the 2nd bit of 4'b1111:
   - All outputs 0 the next cycle and no further strobes.
   - A load_valid held during reset is not accepted (load_ready=0).
   - After rst drops, the word is accepted fresh.
6. Change data_in every cycle during a word; pulse load_valid while busy outside the last-bit cycle:
   - Transmitted bits match the originally captured word.
   - No extra acceptance occurs.
